// File: rtl/tlc.sv
// Two-road traffic light controller: six-state Moore FSM that sequences road A and
// road B through green, yellow and all-red, holding each green while its sensor is set.
module tlc (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       Ta,
  input  logic       Tb,
  output logic       ALRED,
  output logic       ALYELLOW,
  output logic       ALGREEN,
  output logic       BLRED,
  output logic       BLYELLOW,
  output logic       BLGREEN,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S0 = 3'd0;  // A green,  B red
  localparam logic [2:0] S1 = 3'd1;  // A yellow, B red
  localparam logic [2:0] S2 = 3'd2;  // all red, handing over to B
  localparam logic [2:0] S3 = 3'd3;  // A red,    B green
  localparam logic [2:0] S4 = 3'd4;  // A red,    B yellow
  localparam logic [2:0] S5 = 3'd5;  // all red, handing back to A

  logic [2:0] state_q;
  logic [2:0] state_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the two green states look at a sensor; every other state is a single cycle.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = Ta ? S0 : S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = Tb ? S3 : S4;
      S4:      state_d = S5;
      S5:      state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Lamps decode from the state register alone; illegal codes show all-red.
  always_comb begin
    ALRED    = 1'b1;
    ALYELLOW = 1'b0;
    ALGREEN  = 1'b0;
    BLRED    = 1'b1;
    BLYELLOW = 1'b0;
    BLGREEN  = 1'b0;
    case (state_q)
      S0: begin
        ALRED   = 1'b0;
        ALGREEN = 1'b1;
      end
      S1: begin
        ALRED    = 1'b0;
        ALYELLOW = 1'b1;
      end
      S3: begin
        BLRED   = 1'b0;
        BLGREEN = 1'b1;
      end
      S4: begin
        BLRED    = 1'b0;
        BLYELLOW = 1'b1;
      end
      default: begin
        ALRED = 1'b1;
        BLRED = 1'b1;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_tlc.sv
// Directed bench for tlc: drivers push expected {state, lamps} per clock edge into a
// queue, and an independent monitor pops and compares one entry after every rising edge.
module tb_tlc;

  logic       CLK;
  logic       RESET_N;
  logic       Ta;
  logic       Tb;
  logic       ALRED, ALYELLOW, ALGREEN, BLRED, BLYELLOW, BLGREEN;
  logic [2:0] state_dbg;
  logic [5:0] lamps;

  logic [8:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  tlc dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .Ta       (Ta),
    .Tb       (Tb),
    .ALRED    (ALRED),
    .ALYELLOW (ALYELLOW),
    .ALGREEN  (ALGREEN),
    .BLRED    (BLRED),
    .BLYELLOW (BLYELLOW),
    .BLGREEN  (BLGREEN),
    .state_dbg(state_dbg)
  );

  assign lamps = {ALRED, ALYELLOW, ALGREEN, BLRED, BLYELLOW, BLGREEN};

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hand-written lamp table {ALRED, ALYELLOW, ALGREEN, BLRED, BLYELLOW, BLGREEN}
  function automatic logic [8:0] entry(input int s);
    logic [5:0] l;
    case (s)
      0:       l = 6'b001_100;
      1:       l = 6'b010_100;
      2:       l = 6'b100_100;
      3:       l = 6'b100_001;
      4:       l = 6'b100_010;
      default: l = 6'b100_100;
    endcase
    return {s[2:0], l};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d lamps=%b, expected state=%0d lamps=%b",
               name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
    end
  endtask

  // driver: apply sensors away from the edge, record what the next edge must produce
  task automatic step(input logic ta, input logic tb, input int exp_state);
    @(negedge CLK);
    Ta = ta;
    Tb = tb;
    exp_q.push_back(entry(exp_state));
  endtask

  // Walk from S1 to state k, drop reset between edges, check lamps react at once.
  task automatic async_reset_from(input int k);
    for (int j = 2; j <= k; j++) step(1'b0, 1'b0, j);
    @(negedge CLK);
    Ta = 1'b0;
    Tb = 1'b0;
    #2 RESET_N = 1'b0;
    #1 check($sformatf("async_reset_from_s%0d", k), {state_dbg, lamps}, entry(0));
    @(negedge CLK);
    check($sformatf("reset_held_s%0d", k), {state_dbg, lamps}, entry(0));
    RESET_N = 1'b1;
    exp_q.push_back(entry(1));
  endtask

  // scoreboard monitor
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge", {state_dbg, lamps}, e);
      end
    end
  end

  // continuous lamp-rule checks, sampled mid-cycle
  always @(negedge CLK) begin
    if (RESET_N) begin
      n_tests++;
      if (!$onehot({ALRED, ALYELLOW, ALGREEN}) || !$onehot({BLRED, BLYELLOW, BLGREEN})
          || (ALGREEN && !BLRED) || (BLGREEN && !ALRED)) begin
        n_fail++;
        $display("FAIL lamp_rules: got lamps=%b, required one lamp per road and no conflicting green",
                 lamps);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET_N = 1'b0;
    Ta      = 1'b1;
    Tb      = 1'b0;
    #3 check("reset_async_t0", {state_dbg, lamps}, entry(0));
    repeat (2) @(posedge CLK);
    #1 check("reset_held", {state_dbg, lamps}, entry(0));

    // release with Ta=1: A green holds, then Ta drop moves to A yellow
    @(negedge CLK);
    RESET_N = 1'b1;
    exp_q.push_back(entry(0));
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1);

    // full cycle with both sensors idle
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1);

    // sensors set during single-cycle states do not stall; B holds while Tb=1, Ta ignored
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 3);
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 4);
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b1, 0);
    // in S0, Tb toggling is ignored; Ta=Tb=1 loops S0
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);

    // asynchronous reset from every state S1..S5
    step(1'b0, 1'b0, 1);
    for (int k = 1; k <= 5; k++) async_reset_from(k);
    step(1'b0, 1'b0, 2);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc.md
Name: tlc

Overview:
- Two-road traffic light controller. Road A and road B each have one red, one yellow and one green lamp.
- Six-state Moore FSM driven by per-road traffic sensors Ta and Tb.
- Road A keeps green while traffic is present on A. The FSM then sequences A yellow, all-red, B green, B yellow, all-red, and returns to A green.
- Sits at the top of the intersection control path and drives lamp drivers directly.

Parameters:
- none (state timing is one clock per state except the two sensor-held green states)

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET_N  input  1  asynchronous, active-low reset; forces state S0
- Ta  input  1  traffic sensor, road A (1 = traffic present)
- Tb  input  1  traffic sensor, road B (1 = traffic present)
- ALRED  output  1  road A red lamp
- ALYELLOW  output  1  road A yellow lamp
- ALGREEN  output  1  road A green lamp
- BLRED  output  1  road B red lamp
- BLYELLOW  output  1  road B yellow lamp
- BLGREEN  output  1  road B green lamp

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low.
  - While RESET_N=0 the state is S0 immediately, independent of CLK, and held there.
  - On RESET_N release, the first rising CLK edge evaluates transitions from S0.
- State register:
  - 3 bits, encodings S0..S5 = 0..5.
  - Codes 6 and 7 are illegal; from an illegal code the next rising edge goes to S0, with all-red outputs meanwhile.
- Transitions, evaluated on rising CLK edge with RESET_N=1. Ta and Tb are sampled at the edge.
  - S0 (A green): Ta=1 -> S0; Ta=0 -> S1. Tb is ignored.
  - S1 (A yellow): -> S2 unconditionally.
  - S2 (all red): -> S3 unconditionally.
  - S3 (B green): Tb=1 -> S3; Tb=0 -> S4. Ta is ignored.
  - S4 (B yellow): -> S5 unconditionally.
  - S5 (all red): -> S0 unconditionally.
- Outputs are Moore, decoded combinationally from the state register only; no input-to-output path.
  - S0: ALGREEN=1, BLRED=1
  - S1: ALYELLOW=1, BLRED=1
  - S2: ALRED=1, BLRED=1
  - S3: ALRED=1, BLGREEN=1
  - S4: ALRED=1, BLYELLOW=1
  - S5: ALRED=1, BLRED=1
  - All other lamp outputs are 0 in each state.
- Per-road lamp rules:
  - Exactly one lamp per road is 1 at all times.
  - Green on A and any non-red on B are never simultaneous, and vice versa.
- Reset values: ALGREEN=1, BLRED=1, all other outputs 0.
- Latency: a sensor change affects state, and therefore lamps, on the next rising edge.
- Minimum dwell times:
  - S1, S2, S4 and S5 last exactly one cycle.
  - S0 and S3 last at least one cycle and extend while their sensor stays 1.
- Sensor hold:
  - Ta=1 forever holds S0 indefinitely.
  - Tb=1 forever holds S3 indefinitely.
  - There is no timeout.
- Reset mid-operation: asserting RESET_N=0 in any state S1..S5 returns to S0 asynchronously; outputs update without waiting for a clock.

Test Plan:
- Reset in S0 with Ta=1, Tb=0: RESET_N=0, then release. Stays S0 while Ta=1 (ALGREEN=1, BLRED=1). Ta=0 -> next edge S1 (ALYELLOW=1, BLRED=1).
- Full cycle with Ta=Tb=0 throughout: S0->S1->S2->S3->S4->S5->S0, one edge each. Lamps match the decode table each cycle; S2 and S5 show ALRED=BLRED=1.
- Sensor hold in S3 and ignored inputs:
  - Reach S3 with Tb=1 and hold Tb=1 for 2 edges -> remains S3 (ALRED=1, BLGREEN=1).
  - Tb=0 -> S4 (BLYELLOW=1).
  - Ta=1, Tb=1 during S1/S2/S4/S5 does not stall these states.
- Asynchronous reset from each state S1..S5: drive RESET_N=0 between clock edges -> outputs go to ALGREEN=1, BLRED=1 before the next edge. After release with Ta=0, the next edge gives S1.
- Input independence:
  - In S0, toggling Tb has no effect.
  - In S3, toggling Ta has no effect.
  - Outputs never glitch between edges.
- Continuous checks:
  - Every cycle, exactly one lamp per road is 1.
  - ALGREEN and BLGREEN are never both 1.
  - Back-to-back cycles with Ta=Tb=1 loop S0 forever.
